// File: rtl/adc_ctrl_pkg.sv
// Shared constants and FSM state encoding for the ADC conversion sequencer.
package adc_ctrl_pkg;

    localparam int unsigned ADC_DW        = 12;
    localparam int unsigned ADC_FRAME_LEN = 18;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// ADC receiver handshake plus downstream sample valid/ready channel.
interface adc_sample_sequencer_if #(
    parameter int unsigned CH_W = 4
);
    import adc_ctrl_pkg::*;

    logic              adc_inicio;
    logic              adc_listo;
    logic [ADC_DW-1:0] adc_dato;
    logic [CH_W-1:0]   adc_chan;
    logic [ADC_DW-1:0] sample_data;
    logic [CH_W-1:0]   sample_chan;
    logic              sample_valid;
    logic              sample_ready;

    // Sequencer side.
    modport master (
        output adc_inicio, adc_chan, sample_data, sample_chan, sample_valid,
        input  adc_listo, adc_dato, sample_ready
    );

    // Receiver / consumer side.
    modport slave (
        input  adc_inicio, adc_chan, sample_data, sample_chan, sample_valid,
        output adc_listo, adc_dato, sample_ready
    );

endinterface

// File: rtl/adc_period_timer.sv
// Free-running conversion period timer; tick is high during the cycle the count sits at PERIOD-1.
module adc_period_timer #(
    parameter int unsigned PERIOD = 48
) (
    input  logic clock44kHz,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(PERIOD - 2);

    logic [CNT_W-1:0] count;

    // Count while enabled, clear when disabled; tick is registered one step ahead of the wrap.
    always_ff @(posedge clock44kHz or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
            tick  <= (count == CNT_PRE_LAST);
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Periodically starts ADC conversions, captures tagged samples and offers them on valid/ready.
module adc_sample_sequencer
    import adc_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD  = 48,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned NUM_CH  = 1,
    parameter int unsigned CH_W    = 4,
    parameter int unsigned OVF_W   = 8
) (
    input  logic                  clock44kHz,
    input  logic                  reset,
    input  logic                  enable,
    adc_sample_sequencer_if.master bus,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [OVF_W-1:0]      overrun_cnt
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    // Reject parameter sets the sequencing cannot honour.
    if (PERIOD < 4) begin : g_bad_period
        $error("adc_sample_sequencer: PERIOD must be at least 4");
    end
    if (TIMEOUT <= ADC_FRAME_LEN) begin : g_bad_timeout
        $error("adc_sample_sequencer: TIMEOUT must exceed the receiver frame length");
    end

    seq_state_e        state;
    seq_state_e        state_next;
    logic              tick;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit;
    logic              capture_c;
    logic              abort_c;
    logic              load_c;
    logic              drop_c;
    logic              accept_c;

    logic              inicio_q;
    logic [CH_W-1:0]   adc_chan_q;
    logic [ADC_DW-1:0] sample_data_q;
    logic [CH_W-1:0]   sample_chan_q;
    logic              sample_valid_q;

    adc_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clock44kHz (clock44kHz),
        .reset      (reset),
        .enable     (enable),
        .tick       (tick)
    );

    assign to_hit = (to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clock44kHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ticks outside IDLE are simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (tick) state_next = START;
            START:     state_next = WAIT_DONE;
            WAIT_DONE: if (bus.adc_listo || to_hit) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Conversion outcome and capture decision for the current cycle.
    always_comb begin
        capture_c = 1'b0;
        abort_c   = 1'b0;
        if (state == WAIT_DONE) begin
            if (bus.adc_listo) begin
                capture_c = 1'b1;
            end else if (to_hit) begin
                abort_c = 1'b1;
            end
        end
        accept_c = sample_valid_q && bus.sample_ready;
        load_c   = capture_c && (!sample_valid_q || accept_c);
        drop_c   = capture_c && !load_c;
    end

    // Registered control outputs, timeout counter and channel round-robin.
    always_ff @(posedge clock44kHz or posedge reset) begin
        if (reset) begin
            inicio_q    <= 1'b0;
            busy        <= 1'b0;
            to_cnt      <= '0;
            adc_chan_q  <= '0;
            timeout_err <= 1'b0;
        end else begin
            inicio_q <= (state_next == START);
            busy     <= (state_next != IDLE);
            if (state == START) begin
                to_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (capture_c || abort_c) begin
                adc_chan_q <= (adc_chan_q == CH_LAST) ? '0 : adc_chan_q + CH_W'(1);
            end
            if (abort_c) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Output sample holding register with overrun accounting.
    always_ff @(posedge clock44kHz or posedge reset) begin
        if (reset) begin
            sample_data_q  <= '0;
            sample_chan_q  <= '0;
            sample_valid_q <= 1'b0;
            overrun_cnt    <= '0;
        end else begin
            if (load_c) begin
                sample_data_q  <= bus.adc_dato;
                sample_chan_q  <= adc_chan_q;
                sample_valid_q <= 1'b1;
            end else if (accept_c) begin
                sample_valid_q <= 1'b0;
            end
            if (drop_c && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + OVF_W'(1);
            end
        end
    end

    assign bus.adc_inicio   = inicio_q;
    assign bus.adc_chan     = adc_chan_q;
    assign bus.sample_data  = sample_data_q;
    assign bus.sample_chan  = sample_chan_q;
    assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with a behavioural ADC receiver model.
module tb_adc_sample_sequencer;
    import adc_ctrl_pkg::*;

    localparam int unsigned PERIOD  = 8;
    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 4;
    localparam int unsigned OVF_W   = 8;

    logic             clock44kHz = 1'b0;
    logic             reset;
    logic             enable;
    logic             busy;
    logic             timeout_err;
    logic [OVF_W-1:0] overrun_cnt;

    logic        m_listo;
    logic        stray_listo;
    logic        ready;
    logic        mute;
    logic [11:0] m_dato;
    logic [11:0] model_data;
    int          m_cnt;
    int          cyc;
    int          n_checks;
    int          n_fail;

    adc_sample_sequencer_if #(.CH_W(CH_W)) bus ();

    assign bus.adc_listo    = m_listo | stray_listo;
    assign bus.adc_dato     = m_dato;
    assign bus.sample_ready = ready;

    adc_sample_sequencer #(
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT),
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W),
        .OVF_W   (OVF_W)
    ) dut (
        .clock44kHz  (clock44kHz),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clock44kHz = ~clock44kHz;

    // Receiver model: listo (with the next data word) 18 cycles after inicio unless muted.
    always @(negedge clock44kHz) begin
        m_listo = 1'b0;
        if (reset) begin
            m_cnt = 0;
        end else if (bus.adc_inicio) begin
            m_cnt = 1;
        end else if (m_cnt != 0) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 19) begin
                m_cnt = 0;
                if (!mute) begin
                    m_listo    = 1'b1;
                    m_dato     = model_data;
                    model_data = model_data + 12'd1;
                end
            end
        end
    end

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clock44kHz);
            cyc++;
        end
    endtask

    // Reset, then raise enable at a falling edge; cyc counts falling edges from there.
    task automatic start_run(input logic rdy, input logic [11:0] d, input logic mt);
        @(posedge clock44kHz);
        #1;
        reset       = 1'b1;
        enable      = 1'b0;
        ready       = rdy;
        model_data  = d;
        mute        = mt;
        stray_listo = 1'b0;
        @(negedge clock44kHz);
        @(negedge clock44kHz);
        reset = 1'b0;
        @(negedge clock44kHz);
        enable = 1'b1;
        cyc    = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clock44kHz);
        n_checks++;
        if ({bus.adc_inicio, busy, bus.sample_valid, timeout_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.adc_inicio, busy, bus.sample_valid, timeout_err});
        end
        n_checks++;
        if ({bus.sample_data, bus.sample_chan, bus.adc_chan, overrun_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: data %h chan %h adc_chan %h ovr %h want all 0",
                     bus.sample_data, bus.sample_chan, bus.adc_chan, overrun_cnt);
        end
    endtask

    task automatic test_basic();
        start_run(1'b1, 12'hA5C, 1'b0);
        step_to(4);
        stray_listo = 1'b1;
        step_to(5);
        stray_listo = 1'b0;
        n_checks++;
        if (bus.sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_stray_listo: valid %b want 0", bus.sample_valid);
        end
        step_to(7);
        n_checks++;
        if (bus.adc_inicio !== 1'b0) begin
            n_fail++; $display("FAIL basic_inicio_c7: got %b want 0", bus.adc_inicio);
        end
        step_to(8);
        n_checks++;
        if ({bus.adc_inicio, busy, bus.adc_chan} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL basic_start_c8: inicio %b busy %b chan %0d want 1 1 0",
                     bus.adc_inicio, busy, bus.adc_chan);
        end
        step_to(9);
        n_checks++;
        if ({bus.adc_inicio, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_pulse_c9: inicio %b busy %b want 0 1", bus.adc_inicio, busy);
        end
        step_to(26);
        n_checks++;
        if (bus.sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_valid_c26: got %b want 0", bus.sample_valid);
        end
        step_to(27);
        n_checks++;
        if ({bus.sample_valid, bus.sample_data, bus.sample_chan} !== {1'b1, 12'hA5C, 4'd0}) begin
            n_fail++;
            $display("FAIL basic_sample0: valid %b data %h chan %0d want 1 a5c 0",
                     bus.sample_valid, bus.sample_data, bus.sample_chan);
        end
        n_checks++;
        if ({busy, bus.adc_chan} !== {1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL basic_after_cap: busy %b adc_chan %0d want 0 1", busy, bus.adc_chan);
        end
        step_to(28);
        n_checks++;
        if (bus.sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_accepted: valid %b want 0", bus.sample_valid);
        end
        step_to(32);
        n_checks++;
        if (bus.adc_inicio !== 1'b1) begin
            n_fail++; $display("FAIL basic_inicio_c32: got %b want 1", bus.adc_inicio);
        end
        step_to(51);
        n_checks++;
        if ({bus.sample_valid, bus.sample_data, bus.sample_chan} !== {1'b1, 12'hA5D, 4'd1}) begin
            n_fail++;
            $display("FAIL basic_sample1: valid %b data %h chan %0d want 1 a5d 1",
                     bus.sample_valid, bus.sample_data, bus.sample_chan);
        end
    endtask

    task automatic test_overrun();
        start_run(1'b0, 12'h100, 1'b0);
        step_to(27);
        n_checks++;
        if ({bus.sample_valid, bus.sample_data, overrun_cnt} !== {1'b1, 12'h100, 8'd0}) begin
            n_fail++;
            $display("FAIL ovr_first: valid %b data %h ovr %0d want 1 100 0",
                     bus.sample_valid, bus.sample_data, overrun_cnt);
        end
        step_to(51);
        n_checks++;
        if ({bus.sample_data, overrun_cnt} !== {12'h100, 8'd1}) begin
            n_fail++;
            $display("FAIL ovr_second: data %h ovr %0d want 100 1", bus.sample_data, overrun_cnt);
        end
        step_to(75);
        n_checks++;
        if ({bus.sample_valid, bus.sample_data, bus.sample_chan, overrun_cnt}
                !== {1'b1, 12'h100, 4'd0, 8'd2}) begin
            n_fail++;
            $display("FAIL ovr_third: valid %b data %h chan %0d ovr %0d want 1 100 0 2",
                     bus.sample_valid, bus.sample_data, bus.sample_chan, overrun_cnt);
        end
        ready = 1'b1;
        step_to(76);
        n_checks++;
        if (bus.sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovr_accept: valid %b want 0", bus.sample_valid);
        end
        step_to(99);
        n_checks++;
        if ({bus.sample_valid, bus.sample_data, bus.sample_chan, overrun_cnt}
                !== {1'b1, 12'h103, 4'd3, 8'd2}) begin
            n_fail++;
            $display("FAIL ovr_fresh: valid %b data %h chan %0d ovr %0d want 1 103 3 2",
                     bus.sample_valid, bus.sample_data, bus.sample_chan, overrun_cnt);
        end
    endtask

    task automatic test_timeout();
        start_run(1'b1, 12'h200, 1'b1);
        step_to(40);
        n_checks++;
        if ({timeout_err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL to_before: err %b busy %b want 0 1", timeout_err, busy);
        end
        step_to(41);
        n_checks++;
        if ({timeout_err, busy, bus.sample_valid, bus.adc_chan} !== {3'b100, 4'd1}) begin
            n_fail++;
            $display("FAIL to_abort: err %b busy %b valid %b chan %0d want 1 0 0 1",
                     timeout_err, busy, bus.sample_valid, bus.adc_chan);
        end
        step_to(42);
        mute = 1'b0;
        step_to(48);
        n_checks++;
        if ({bus.adc_inicio, bus.adc_chan} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL to_restart: inicio %b chan %0d want 1 1", bus.adc_inicio, bus.adc_chan);
        end
        step_to(67);
        n_checks++;
        if ({bus.sample_valid, bus.sample_data, bus.sample_chan, timeout_err}
                !== {1'b1, 12'h200, 4'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL to_recover: valid %b data %h chan %0d err %b want 1 200 1 1",
                     bus.sample_valid, bus.sample_data, bus.sample_chan, timeout_err);
        end
    endtask

    task automatic test_channels();
        logic [CH_W-1:0] exp_chan;
        start_run(1'b1, 12'h300, 1'b0);
        for (int k = 0; k < 5; k++) begin
            exp_chan = CH_W'(k % NUM_CH);
            step_to(27 + 24 * k);
            n_checks++;
            if ({bus.sample_valid, bus.sample_chan} !== {1'b1, exp_chan}) begin
                n_fail++;
                $display("FAIL chan_rr_%0d: valid %b chan %0d want 1 %0d",
                         k, bus.sample_valid, bus.sample_chan, exp_chan);
            end
        end
    endtask

    task automatic test_disable();
        int starts;
        start_run(1'b1, 12'h400, 1'b0);
        step_to(15);
        enable = 1'b0;
        step_to(27);
        n_checks++;
        if ({bus.sample_valid, bus.sample_data} !== {1'b1, 12'h400}) begin
            n_fail++;
            $display("FAIL dis_complete: valid %b data %h want 1 400",
                     bus.sample_valid, bus.sample_data);
        end
        starts = 0;
        while (cyc < 90) begin
            step_to(cyc + 1);
            if (bus.adc_inicio === 1'b1) starts++;
        end
        n_checks++;
        if (starts !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_idle: starts %0d busy %b want 0 0", starts, busy);
        end
        enable = 1'b1;
        cyc    = 0;
        step_to(7);
        n_checks++;
        if (bus.adc_inicio !== 1'b0) begin
            n_fail++; $display("FAIL dis_reen_c7: inicio %b want 0", bus.adc_inicio);
        end
        step_to(8);
        n_checks++;
        if (bus.adc_inicio !== 1'b1) begin
            n_fail++; $display("FAIL dis_reen_c8: inicio %b want 1", bus.adc_inicio);
        end
    endtask

    task automatic test_saturate_and_reset();
        start_run(1'b0, 12'h000, 1'b0);
        step_to(27 + 24 * 254);
        n_checks++;
        if (overrun_cnt !== 8'hFE) begin
            n_fail++; $display("FAIL sat_fe: ovr %h want fe", overrun_cnt);
        end
        step_to(27 + 24 * 255);
        n_checks++;
        if (overrun_cnt !== 8'hFF) begin
            n_fail++; $display("FAIL sat_ff: ovr %h want ff", overrun_cnt);
        end
        step_to(27 + 24 * 257);
        n_checks++;
        if ({overrun_cnt, bus.sample_valid, bus.sample_data} !== {8'hFF, 1'b1, 12'h000}) begin
            n_fail++;
            $display("FAIL sat_hold: ovr %h valid %b data %h want ff 1 000",
                     overrun_cnt, bus.sample_valid, bus.sample_data);
        end
        step_to(40 + 24 * 257);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_busy: busy %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.adc_inicio, busy, bus.sample_valid, timeout_err, overrun_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_ctrl: inicio %b busy %b valid %b err %b ovr %h want 0",
                     bus.adc_inicio, busy, bus.sample_valid, timeout_err, overrun_cnt);
        end
        n_checks++;
        if ({bus.sample_data, bus.sample_chan, bus.adc_chan} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_data: data %h chan %0d adc_chan %0d want 0",
                     bus.sample_data, bus.sample_chan, bus.adc_chan);
        end
        @(negedge clock44kHz);
        reset = 1'b0;
    endtask

    // Bound the whole run so a stuck sequence still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        m_cnt       = 0;
        m_listo     = 1'b0;
        m_dato      = 12'h000;
        model_data  = 12'h000;
        stray_listo = 1'b0;
        ready       = 1'b1;
        mute        = 1'b0;
        enable      = 1'b0;
        reset       = 1'b1;
        test_reset();
        test_basic();
        test_overrun();
        test_timeout();
        test_channels();
        test_disable();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
